i2c_slave_reg_ctrl: RTL and testbench

//  Register-map controller on the byte interface of I2C_slave; turns the slave into an addressable register bank.
//  - Master write: 1st data byte loads the register pointer; following bytes write regs[ptr], ptr auto-increments.
//  - Master read: returns regs[ptr] per byte, ptr auto-increments. The pointer persists across transactions
//    (write-pointer then repeated-start read). The local host reads/writes the same bank via a side port.

---
 rtl/i2c_slave_reg_ctrl_if.sv | 29 ++
 rtl/i2c_slave_reg_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_slave_reg_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_reg_ctrl_if.sv
// Byte-level link between the I2C slave core and the register-map controller.
// "master" is the I2C slave core side, which produces bytes and bus events.
// "slave" is the register controller side, which supplies the next transmit byte.
interface i2c_slave_reg_ctrl_if;
    logic [7:0] byte_read_o;
    logic       read_write_flag;
    logic       byte_finish;
    logic       transmit_busy;
    logic       transmit_err;
    logic [7:0] byte_write_i;

    modport master (
        output byte_read_o,
        output read_write_flag,
        output byte_finish,
        output transmit_busy,
        output transmit_err,
        input  byte_write_i
    );

    modport slave (
        input  byte_read_o,
        input  read_write_flag,
        input  byte_finish,
        input  transmit_busy,
        input  transmit_err,
        output byte_write_i
    );
endinterface

// File: rtl/i2c_slave_reg_ctrl.sv
// Register-map controller for an I2C slave byte interface.
// The first data byte of a master write loads the register pointer. Each later
// byte is written to regs[ptr], and the pointer then advances. Each byte the
// master reads comes from regs[ptr], and the pointer then advances.
// The pointer persists across transactions, so write-pointer plus repeated-start
// read works. A local host shares the bank through a side port.
module i2c_slave_reg_ctrl #(
    parameter int                 REG_NUM   = 16,
    parameter int                 PTR_W     = 4,
    parameter logic [REG_NUM-1:0] RO_MASK   = 16'h0001,
    parameter int                 AUTO_WRAP = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_slave_reg_ctrl_if.slave   bus,
    input  logic [PTR_W-1:0]      host_addr,
    input  logic                  host_wr_en,
    input  logic [7:0]            host_wdata,
    output logic [7:0]            host_rdata,
    output logic                  reg_update,
    output logic [PTR_W-1:0]      reg_update_addr,
    output logic [PTR_W-1:0]      ptr_o,
    output logic [2:0]            status_o,
    input  logic                  status_clr
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(REG_NUM - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRST   = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    // Returns the advanced pointer in the low bits and, in the top bit, a flag
    // that is set when the pointer had to saturate at the last register.
    function automatic logic [PTR_W:0] advance_ptr(input logic [PTR_W-1:0] p);
        logic [PTR_W:0] res;
        if (p == LAST_IDX) begin
            if (AUTO_WRAP != 0) begin
                res = {1'b0, {PTR_W{1'b0}}};
            end else begin
                res = {1'b1, p};
            end
        end else begin
            res = {1'b0, p + {{(PTR_W-1){1'b0}}, 1'b1}};
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    state_t            byte_state_s;
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  ptr_nxt_s;
    logic              sat_r;          // pointer pinned at the last index by an overflow
    logic              sat_nxt_s;
    logic              busy_q_r;
    logic              busy_rise_s;
    logic              busy_fall_s;
    logic              out_of_range_s;
    logic [PTR_W:0]    adv_s;
    logic              i2c_we_s;
    logic              host_we_s;
    logic              err_set_s;
    logic              ovr_set_s;
    logic              ro_set_s;
    logic [2:0]        status_r;
    logic              reg_update_r;
    logic [PTR_W-1:0]  reg_update_addr_r;
    logic [7:0]        byte_write_r;
    logic [7:0]        host_rdata_r;
    logic [7:0]        host_view_s;
    logic [7:0]        bus_view_s;
    logic [7:0]        regs_r [REG_NUM];

    assign busy_rise_s    = bus.transmit_busy & ~busy_q_r;
    assign busy_fall_s    = ~bus.transmit_busy & busy_q_r;
    assign out_of_range_s = ({24'd0, bus.byte_read_o} >= REG_NUM);
    assign host_we_s      = host_wr_en & ~(i2c_we_s & (ptr_r == host_addr));

    assign bus.byte_write_i = byte_write_r;
    assign host_rdata       = host_rdata_r;
    assign reg_update       = reg_update_r;
    assign reg_update_addr  = reg_update_addr_r;
    assign ptr_o            = ptr_r;
    assign status_o         = status_r;

    // Next-state decode: FSM transition, pointer update, I2C write enable, status events
    always_comb begin
        state_nxt_s  = state_r;
        byte_state_s = state_r;
        ptr_nxt_s    = ptr_r;
        sat_nxt_s    = sat_r;
        i2c_we_s     = 1'b0;
        err_set_s    = 1'b0;
        ovr_set_s    = 1'b0;
        ro_set_s     = 1'b0;
        adv_s        = advance_ptr(ptr_r);
        if (bus.transmit_err) begin
            // Bus error aborts the transaction; the pointer is kept and nothing is written
            state_nxt_s = IDLE;
            err_set_s   = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (busy_rise_s) begin
                        state_nxt_s = FIRST;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                FIRST, WR_DATA, RD_DATA: begin
                    if (bus.byte_finish) begin
                        if (bus.read_write_flag && (state_r != WR_DATA)) begin
                            // First written byte (or repeated start into write) is the pointer
                            byte_state_s = WR_DATA;
                            if (out_of_range_s) begin
                                ptr_nxt_s = LAST_IDX;
                                sat_nxt_s = 1'b1;
                                ovr_set_s = 1'b1;
                            end else begin
                                ptr_nxt_s = bus.byte_read_o[PTR_W-1:0];
                                sat_nxt_s = 1'b0;
                            end
                        end else if (bus.read_write_flag) begin
                            // Data byte: protected or saturated targets are skipped but still advance
                            byte_state_s = WR_DATA;
                            ro_set_s     = RO_MASK[ptr_r];
                            i2c_we_s     = ~RO_MASK[ptr_r] & ~sat_r;
                            ovr_set_s    = sat_r | adv_s[PTR_W];
                            ptr_nxt_s    = adv_s[PTR_W-1:0];
                            sat_nxt_s    = adv_s[PTR_W];
                        end else begin
                            // Byte just sent to the master was regs[ptr]; move to the next one
                            byte_state_s = RD_DATA;
                            ovr_set_s    = adv_s[PTR_W];
                            ptr_nxt_s    = adv_s[PTR_W-1:0];
                            sat_nxt_s    = adv_s[PTR_W];
                        end
                    end else begin
                        byte_state_s = state_r;
                    end
                    if (busy_fall_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = byte_state_s;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Write-first views of the bank for the two registered read ports
    always_comb begin
        if (i2c_we_s && (ptr_r == host_addr)) begin
            host_view_s = bus.byte_read_o;
        end else if (host_we_s) begin
            host_view_s = host_wdata;
        end else begin
            host_view_s = regs_r[host_addr];
        end
        if (i2c_we_s && (ptr_r == ptr_nxt_s)) begin
            bus_view_s = bus.byte_read_o;
        end else if (host_we_s && (host_addr == ptr_nxt_s)) begin
            bus_view_s = host_wdata;
        end else begin
            bus_view_s = regs_r[ptr_nxt_s];
        end
    end

    // FSM state, pointer, sticky status and the I2C write notification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= IDLE;
            ptr_r             <= {PTR_W{1'b0}};
            sat_r             <= 1'b0;
            // Treat busy as already high so a transaction cut by reset is not re-entered
            busy_q_r          <= 1'b1;
            status_r          <= 3'b000;
            reg_update_r      <= 1'b0;
            reg_update_addr_r <= {PTR_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            ptr_r        <= ptr_nxt_s;
            sat_r        <= sat_nxt_s;
            busy_q_r     <= bus.transmit_busy;
            status_r     <= (status_clr ? 3'b000 : status_r) | {err_set_s, ovr_set_s, ro_set_s};
            reg_update_r <= i2c_we_s;
            if (i2c_we_s) begin
                reg_update_addr_r <= ptr_r;
            end else begin
                reg_update_addr_r <= reg_update_addr_r;
            end
        end
    end

    // Register bank; on a shared index the I2C write wins over the host
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            if (i2c_we_s) begin
                regs_r[ptr_r] <= bus.byte_read_o;
            end
            if (host_we_s) begin
                regs_r[host_addr] <= host_wdata;
            end
        end
    end

    // Registered read ports: next transmit byte and host read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_write_r <= 8'h00;
            host_rdata_r <= 8'h00;
        end else begin
            byte_write_r <= bus_view_s;
            host_rdata_r <= host_view_s;
        end
    end

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Bench for i2c_slave_reg_ctrl.
// Two instances are driven with identical stimulus: one wraps the pointer and
// one saturates it. Each is compared against a byte-level reference model of
// the register map.
module tb_i2c_slave_reg_ctrl;
    localparam int N = 16;
    localparam logic [2:0] S_RO  = 3'b001;
    localparam logic [2:0] S_OVR = 3'b010;
    localparam logic [2:0] S_ERR = 3'b100;

    logic            clk;
    logic            rst_n;
    logic [7:0]      b_byte;
    logic            b_rw;
    logic            b_fin;
    logic            b_busy;
    logic            b_err;
    logic [3:0]      host_addr;
    logic            host_wr_en;
    logic [7:0]      host_wdata;
    logic            status_clr;
    logic [1:0][7:0] hrd;
    logic [1:0]      upd;
    logic [1:0][3:0] upd_addr;
    logic [1:0][3:0] ptr;
    logic [1:0][2:0] stat;
    logic [1:0][7:0] bwi;

    int total;
    int bad;

    // Reference model: per-instance register image, pointer, saturation and status
    logic [7:0]  m_regs [2][N];
    int          m_ptr  [2];
    bit          m_sat  [2];
    logic [2:0]  m_stat [2];
    bit          m_active;
    int          m_phase;      // 0: next write byte is a pointer, 1: writing data, 2: reading
    logic [15:0] ro_mask;

    i2c_slave_reg_ctrl_if bus_w ();
    i2c_slave_reg_ctrl_if bus_s ();

    assign bus_w.byte_read_o     = b_byte;
    assign bus_w.read_write_flag = b_rw;
    assign bus_w.byte_finish     = b_fin;
    assign bus_w.transmit_busy   = b_busy;
    assign bus_w.transmit_err    = b_err;
    assign bus_s.byte_read_o     = b_byte;
    assign bus_s.read_write_flag = b_rw;
    assign bus_s.byte_finish     = b_fin;
    assign bus_s.transmit_busy   = b_busy;
    assign bus_s.transmit_err    = b_err;
    assign bwi[0] = bus_w.byte_write_i;
    assign bwi[1] = bus_s.byte_write_i;

    i2c_slave_reg_ctrl #(.REG_NUM(16), .PTR_W(4), .RO_MASK(16'h0001), .AUTO_WRAP(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus_w),
        .host_addr(host_addr), .host_wr_en(host_wr_en), .host_wdata(host_wdata),
        .host_rdata(hrd[0]), .reg_update(upd[0]), .reg_update_addr(upd_addr[0]),
        .ptr_o(ptr[0]), .status_o(stat[0]), .status_clr(status_clr)
    );

    i2c_slave_reg_ctrl #(.REG_NUM(16), .PTR_W(4), .RO_MASK(16'h0001), .AUTO_WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_s),
        .host_addr(host_addr), .host_wr_en(host_wr_en), .host_wdata(host_wdata),
        .host_rdata(hrd[1]), .reg_update(upd[1]), .reg_update_addr(upd_addr[1]),
        .ptr_o(ptr[1]), .status_o(stat[1]), .status_clr(status_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) m_regs[k][i] = 8'h00;
            m_ptr[k]  = 0;
            m_sat[k]  = 1'b0;
            m_stat[k] = 3'b000;
        end
        m_active = 1'b0;
        m_phase  = 0;
    endfunction

    // Instance 0 wraps past the last register; instance 1 sticks there and flags overflow
    function automatic void m_advance(input int k);
        if (m_ptr[k] == N - 1) begin
            if (k == 0) begin
                m_ptr[k] = 0;
                m_sat[k] = 1'b0;
            end else begin
                m_sat[k]  = 1'b1;
                m_stat[k] = m_stat[k] | S_OVR;
            end
        end else begin
            m_ptr[k] = m_ptr[k] + 1;
            m_sat[k] = 1'b0;
        end
    endfunction

    task automatic check_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_ptr"}, k, ptr[k], m_ptr[k]);
            check({tag, "_status"}, k, stat[k], m_stat[k]);
        end
    endtask

    task automatic start_tr;
        b_busy = 1'b1;
        tick;
        tick;
        m_active = 1'b1;
        m_phase  = 0;
    endtask

    task automatic stop_tr;
        b_busy = 1'b0;
        tick;
        tick;
        m_active = 1'b0;
    endtask

    // Master writes one byte; optionally the host writes in the same cycle
    task automatic wr_byte(input logic [7:0] b, input bit hen, input logic [3:0] ha, input logic [7:0] hd);
        bit exp_upd [2];
        int exp_idx [2];
        b_byte = b; b_rw = 1'b1; b_fin = 1'b1;
        host_wr_en = hen; host_addr = ha; host_wdata = hd;
        for (int k = 0; k < 2; k++) begin
            exp_upd[k] = 1'b0;
            exp_idx[k] = m_ptr[k];
            if (m_active && (m_phase != 1)) begin
                if (int'(b) >= N) begin
                    m_ptr[k]  = N - 1;
                    m_sat[k]  = 1'b1;
                    m_stat[k] = m_stat[k] | S_OVR;
                end else begin
                    m_ptr[k] = int'(b);
                    m_sat[k] = 1'b0;
                end
            end else if (m_active) begin
                if (ro_mask[m_ptr[k]]) m_stat[k] = m_stat[k] | S_RO;
                if (m_sat[k]) m_stat[k] = m_stat[k] | S_OVR;
                if (!ro_mask[m_ptr[k]] && !m_sat[k]) begin
                    m_regs[k][m_ptr[k]] = b;
                    exp_upd[k] = 1'b1;
                end
                m_advance(k);
            end
            if (hen && !(exp_upd[k] && (exp_idx[k] == int'(ha)))) m_regs[k][ha] = hd;
        end
        if (m_active) m_phase = 1;
        tick;
        b_fin = 1'b0; host_wr_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("wr_reg_update", k, upd[k], exp_upd[k]);
            if (exp_upd[k]) check("wr_reg_update_addr", k, upd_addr[k], exp_idx[k]);
            check("wr_host_rdata", k, hrd[k], m_regs[k][ha]);
        end
        check_state("wr");
        tick;
    endtask

    // Master reads one byte: the byte offered must be regs[ptr]
    task automatic rd_byte(output logic [7:0] got);
        b_rw = 1'b0;
        got  = bwi[0];
        for (int k = 0; k < 2; k++) check("rd_byte_write_i", k, bwi[k], m_regs[k][m_ptr[k]]);
        b_fin = 1'b1;
        tick;
        b_fin = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (m_active) m_advance(k);
            check("rd_reg_update", k, upd[k], 1'b0);
        end
        if (m_active) m_phase = 2;
        check_state("rd");
        tick;
    endtask

    task automatic err_pulse;
        b_err = 1'b1;
        tick;
        b_err = 1'b0;
        m_active = 1'b0;
        for (int k = 0; k < 2; k++) m_stat[k] = m_stat[k] | S_ERR;
        check_state("err");
        tick;
    endtask

    task automatic clr_status;
        status_clr = 1'b1;
        tick;
        status_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_stat[k] = 3'b000;
            check("clr_status", k, stat[k], 3'b000);
        end
    endtask

    task automatic host_rd(input int a);
        host_addr = 4'(a);
        tick;
        for (int k = 0; k < 2; k++) check("host_rd", k, hrd[k], m_regs[k][a]);
    endtask

    task automatic host_check_all;
        for (int i = 0; i < N; i++) host_rd(i);
        for (int k = 0; k < 2; k++) check("idle_byte_write_i", k, bwi[k], m_regs[k][m_ptr[k]]);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] d;
        logic [7:0] hd;
        logic [3:0] ha;
        bit         hen;
        int         nb;

        total = 0; bad = 0;
        ro_mask = 16'h0001;
        rst_n = 1'b0;
        b_byte = 8'h00; b_rw = 1'b0; b_fin = 1'b0; b_busy = 1'b0; b_err = 1'b0;
        host_addr = 4'h0; host_wr_en = 1'b0; host_wdata = 8'h00; status_clr = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        // Reset state
        for (int k = 0; k < 2; k++) begin
            check("rst_ptr", k, ptr[k], 4'd0);
            check("rst_status", k, stat[k], 3'b000);
            check("rst_reg_update", k, upd[k], 1'b0);
            check("rst_reg_update_addr", k, upd_addr[k], 4'd0);
            check("rst_host_rdata", k, hrd[k], 8'h00);
            check("rst_byte_write_i", k, bwi[k], 8'h00);
        end

        // Pointer 3, then A1, B2
        start_tr;
        wr_byte(8'h03, 1'b0, 4'h0, 8'h00);
        wr_byte(8'hA1, 1'b0, 4'h0, 8'h00);
        wr_byte(8'hB2, 1'b0, 4'h0, 8'h00);
        stop_tr;
        host_rd(3);
        for (int k = 0; k < 2; k++) begin
            check("t1_ptr", k, ptr[k], 4'd5);
            check("t1_reg3", k, hrd[k], 8'hA1);
        end

        // Pointer 3, repeated-start read of two bytes
        start_tr;
        wr_byte(8'h03, 1'b0, 4'h0, 8'h00);
        rd_byte(got);
        check("t2_first_read", 0, got, 8'hA1);
        rd_byte(got);
        check("t2_second_read", 0, got, 8'hB2);
        stop_tr;
        for (int k = 0; k < 2; k++) check("t2_ptr", k, ptr[k], 4'd5);

        // Write to read-only register 0
        start_tr;
        wr_byte(8'h00, 1'b0, 4'h0, 8'h00);
        wr_byte(8'h55, 1'b0, 4'h0, 8'h00);
        stop_tr;
        host_rd(0);
        for (int k = 0; k < 2; k++) begin
            check("t3_status", k, stat[k], 3'b001);
            check("t3_reg0", k, hrd[k], 8'h00);
        end

        // Pointer at the last register: wrap versus saturate
        clr_status;
        start_tr;
        wr_byte(8'h0F, 1'b0, 4'h0, 8'h00);
        wr_byte(8'h11, 1'b0, 4'h0, 8'h00);
        wr_byte(8'h22, 1'b0, 4'h0, 8'h00);
        stop_tr;
        host_rd(15);
        check("t4_ptr_wrap", 0, ptr[0], 4'd1);
        check("t4_ptr_sat", 1, ptr[1], 4'd15);
        check("t4_status_wrap", 0, stat[0], 3'b001);
        check("t4_status_sat", 1, stat[1], 3'b010);
        for (int k = 0; k < 2; k++) check("t4_reg15", k, hrd[k], 8'h11);

        // Bus error after the pointer byte: later bytes are ignored
        clr_status;
        start_tr;
        wr_byte(8'h05, 1'b0, 4'h0, 8'h00);
        err_pulse;
        wr_byte(8'h66, 1'b0, 4'h0, 8'h00);
        stop_tr;
        host_rd(5);
        for (int k = 0; k < 2; k++) begin
            check("t5_status", k, stat[k], 3'b100);
            check("t5_ptr", k, ptr[k], 4'd5);
            check("t5_reg5", k, hrd[k], 8'h00);
        end
        clr_status;

        // Host and I2C write the same index, then different indices
        start_tr;
        wr_byte(8'h04, 1'b0, 4'h0, 8'h00);
        wr_byte(8'h99, 1'b1, 4'h4, 8'h77);
        for (int k = 0; k < 2; k++) check("t6_collide", k, hrd[k], 8'h99);
        wr_byte(8'h5A, 1'b1, 4'h9, 8'h3C);
        stop_tr;
        check_state("t6");

        // A byte_finish pulse while idle does nothing
        wr_byte(8'h0C, 1'b0, 4'h0, 8'h00);
        host_check_all;

        // Reset in the middle of a transaction
        start_tr;
        wr_byte(8'h07, 1'b0, 4'h0, 8'h00);
        wr_byte(8'hC3, 1'b0, 4'h0, 8'h00);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("mid_rst_ptr", k, ptr[k], 4'd0);
            check("mid_rst_status", k, stat[k], 3'b000);
            check("mid_rst_reg_update", k, upd[k], 1'b0);
            check("mid_rst_byte_write_i", k, bwi[k], 8'h00);
            check("mid_rst_host_rdata", k, hrd[k], 8'h00);
        end
        m_reset();
        tick;
        rst_n = 1'b1;
        tick;
        wr_byte(8'h0A, 1'b0, 4'h0, 8'h00);
        stop_tr;
        host_check_all;

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            start_tr;
            nb = int'($urandom_range(1, 6));
            for (int j = 0; j < nb; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rd_byte(got);
                end else begin
                    d   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
                    hen = ($urandom_range(0, 2) == 0);
                    ha  = ($urandom_range(0, 1) == 1) ? 4'(m_ptr[0]) : 4'($urandom_range(0, 15));
                    hd  = 8'($urandom_range(0, 255));
                    wr_byte(d, hen, ha, hd);
                end
            end
            if ($urandom_range(0, 9) == 0) err_pulse;
            stop_tr;
            check_state("rand");
            if ($urandom_range(0, 4) == 0) clr_status;
        end
        host_check_all;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
